// File: rtl/fifo_frame_packer_if.sv
// Stream bundle between the FIFO read port, the frame packer and the host writer.
// The master side is the packer; the slave side is the FIFO plus the downstream sink.
interface fifo_frame_packer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  enable;
    logic [DATA_WIDTH-1:0] fifo_q;
    logic                  fifo_rdempty;
    logic                  fifo_rdreq;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sop;
    logic                  out_eop;
    logic                  out_padded;
    logic [15:0]           frames_sent;

    modport master (
        input  enable,
        input  fifo_q,
        input  fifo_rdempty,
        output fifo_rdreq,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_sop,
        output out_eop,
        output out_padded,
        output frames_sent
    );

    modport slave (
        output enable,
        output fifo_q,
        output fifo_rdempty,
        input  fifo_rdreq,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_sop,
        input  out_eop,
        input  out_padded,
        input  frames_sent
    );
endinterface

// File: rtl/fifo_frame_packer.sv
// Pops show-ahead FIFO words and emits fixed-length frames (SYNC, seq, payload, checksum)
// on a registered valid/ready stream, padding the payload when the FIFO starves.
module fifo_frame_packer #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    FRAME_LEN   = 16,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD   = DATA_WIDTH'(8'hA5),
    parameter logic [DATA_WIDTH-1:0] PAD_WORD    = DATA_WIDTH'(8'h00),
    parameter int                    TIMEOUT_CYC = 255
) (
    input logic                 rdclk,
    input logic                 PresetFull,
    fifo_frame_packer_if.master bus
);

    localparam int LEN_W = $clog2(FRAME_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(FRAME_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    // State names the next word to be emitted.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HEADER   = 3'd1;
    localparam logic [2:0] ST_SEQ      = 3'd2;
    localparam logic [2:0] ST_PAYLOAD  = 3'd3;
    localparam logic [2:0] ST_CHECKSUM = 3'd4;

    logic [2:0]            state_reg,      state_next;
    logic [DATA_WIDTH-1:0] seq_reg,        seq_next;
    logic [DATA_WIDTH-1:0] csum_reg,       csum_next;
    logic [LEN_W-1:0]      len_reg,        len_next;
    logic [TMO_W-1:0]      tmo_reg,        tmo_next;
    logic                  pad_mode_reg,   pad_mode_next;
    logic [DATA_WIDTH-1:0] out_data_reg,   out_data_next;
    logic                  out_valid_reg,  out_valid_next;
    logic                  out_sop_reg,    out_sop_next;
    logic                  out_eop_reg,    out_eop_next;
    logic                  out_padded_reg, out_padded_next;
    logic [15:0]           frames_reg,     frames_next;

    logic                  load;
    logic                  pop;
    logic [DATA_WIDTH-1:0] payload_word;

    // The output register may take a new word when it is empty or being drained.
    assign load         = ~out_valid_reg | bus.out_ready;
    assign pop          = (state_reg == ST_PAYLOAD) & load & ~bus.fifo_rdempty
                          & ~pad_mode_reg & ~PresetFull;
    assign payload_word = pad_mode_reg ? PAD_WORD : bus.fifo_q;

    always_comb begin
        state_next      = state_reg;
        seq_next        = seq_reg;
        csum_next       = csum_reg;
        len_next        = len_reg;
        tmo_next        = tmo_reg;
        pad_mode_next   = pad_mode_reg;
        out_data_next   = out_data_reg;
        out_valid_next  = out_valid_reg;
        out_sop_next    = out_sop_reg;
        out_eop_next    = out_eop_reg;
        out_padded_next = out_padded_reg;
        frames_next     = frames_reg + 16'(bus.out_valid & bus.out_ready & bus.out_eop);

        // Drained with nothing to replace it: bubble, markers cleared.
        if (load) begin
            out_valid_next  = 1'b0;
            out_sop_next    = 1'b0;
            out_eop_next    = 1'b0;
            out_padded_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (bus.enable & ~bus.fifo_rdempty) begin
                    state_next = ST_HEADER;
                end
            end

            ST_HEADER: begin
                if (load) begin
                    out_data_next  = SYNC_WORD;
                    out_valid_next = 1'b1;
                    out_sop_next   = 1'b1;
                    csum_next      = '0;
                    len_next       = '0;
                    tmo_next       = '0;
                    pad_mode_next  = 1'b0;
                    state_next     = ST_SEQ;
                end
            end

            ST_SEQ: begin
                if (load) begin
                    out_data_next  = seq_reg;
                    out_valid_next = 1'b1;
                    state_next     = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                if (load & (~bus.fifo_rdempty | pad_mode_reg)) begin
                    out_data_next  = payload_word;
                    out_valid_next = 1'b1;
                    csum_next      = csum_reg + payload_word;
                    len_next       = len_reg + LEN_W'(1);
                    if (len_reg == LEN_LAST) begin
                        state_next = ST_CHECKSUM;
                    end
                end
                // Starvation timer counts empty cycles regardless of downstream stalls.
                if (bus.fifo_rdempty & ~pad_mode_reg) begin
                    if (tmo_reg == TMO_LAST) begin
                        pad_mode_next = 1'b1;
                        tmo_next      = '0;
                    end else begin
                        tmo_next = tmo_reg + TMO_W'(1);
                    end
                end else if (pop) begin
                    tmo_next = '0;
                end
            end

            ST_CHECKSUM: begin
                if (load) begin
                    out_data_next   = csum_reg;
                    out_valid_next  = 1'b1;
                    out_eop_next    = 1'b1;
                    out_padded_next = pad_mode_reg;
                    seq_next        = seq_reg + DATA_WIDTH'(1);
                    state_next      = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge rdclk or posedge PresetFull) begin
        if (PresetFull) begin
            state_reg      <= ST_IDLE;
            seq_reg        <= '0;
            csum_reg       <= '0;
            len_reg        <= '0;
            tmo_reg        <= '0;
            pad_mode_reg   <= 1'b0;
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            out_sop_reg    <= 1'b0;
            out_eop_reg    <= 1'b0;
            out_padded_reg <= 1'b0;
            frames_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            seq_reg        <= seq_next;
            csum_reg       <= csum_next;
            len_reg        <= len_next;
            tmo_reg        <= tmo_next;
            pad_mode_reg   <= pad_mode_next;
            out_data_reg   <= out_data_next;
            out_valid_reg  <= out_valid_next;
            out_sop_reg    <= out_sop_next;
            out_eop_reg    <= out_eop_next;
            out_padded_reg <= out_padded_next;
            frames_reg     <= frames_next;
        end
    end

    assign bus.fifo_rdreq  = pop;
    assign bus.out_data    = out_data_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_sop     = out_sop_reg;
    assign bus.out_eop     = out_eop_reg;
    assign bus.out_padded  = out_padded_reg;
    assign bus.frames_sent = frames_reg;

endmodule

// File: tb/tb_fifo_frame_packer.sv
// Directed bench for fifo_frame_packer: a show-ahead FIFO model feeds the packer and
// every accepted output word is checked against hand-computed frame contents.
module tb_fifo_frame_packer;

    localparam int DW = 8;

    logic rdclk = 1'b0;
    logic PresetFull;

    fifo_frame_packer_if #(.DATA_WIDTH(DW)) bus();

    fifo_frame_packer #(
        .DATA_WIDTH (DW),
        .FRAME_LEN  (16),
        .SYNC_WORD  (8'hA5),
        .PAD_WORD   (8'h00),
        .TIMEOUT_CYC(4)
    ) dut (
        .rdclk     (rdclk),
        .PresetFull(PresetFull),
        .bus       (bus)
    );

    always #5 rdclk = ~rdclk;

    // Show-ahead FIFO model
    logic [7:0] fmem [0:8191];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops   = 0;
    int cyc    = 0;

    assign bus.fifo_q       = fmem[rd_ptr[12:0]];
    assign bus.fifo_rdempty = (rd_ptr == wr_ptr);

    always @(posedge rdclk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rdreq) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    int checks = 0;
    int fails  = 0;
    int exp_frames = 0;
    int last_sop_cyc = 0;
    int last_eop_cyc = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        int         n_avail;
        logic [7:0] first;
        logic [7:0] step;
        bit         toggle;
        int         exp_lat;
        logic [7:0] exp_seq;
        logic [7:0] exp_csum;
        bit         exp_pad;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_words(input logic [7:0] first, input logic [7:0] step, input int n);
        logic [7:0] w;
        w = first;
        for (int i = 0; i < n; i++) begin
            fmem[wr_ptr[12:0]] = w;
            exp_q.push_back(w);
            wr_ptr++;
            w = w + step;
        end
    endtask

    // Consumes one frame from the stream and checks every word of it.
    task automatic run_frame(input int n_avail, input bit toggle, input int exp_lat,
                             input bit drop_en, input logic [7:0] exp_seq,
                             input logic [7:0] exp_csum, input bit exp_pad);
        int         w;
        int         iter;
        int         pops0;
        bit         done;
        bit         hold;
        logic [7:0] hold_data;
        logic [7:0] exp_w;
        w = 0; iter = 0; pops0 = pops; done = 0; hold = 0; hold_data = '0;
        while (!done && iter < 400) begin
            @(negedge rdclk);
            iter++;
            if (hold) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, hold_data);
            end
            bus.out_ready = toggle ? iter[0] : 1'b1;
            if (bus.fifo_rdreq) chk("rdreq_nonempty", bus.fifo_rdempty, 0);
            hold      = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                if (w == 0) begin
                    exp_w = 8'hA5;
                    last_sop_cyc = cyc;
                    if (exp_lat > 0) chk("sop_latency", iter, exp_lat);
                    if (drop_en) bus.enable = 1'b0;
                end else if (w == 1) begin
                    exp_w = exp_seq;
                end else if (w < 18) begin
                    exp_w = (w - 2 < n_avail && exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                end else begin
                    exp_w = exp_csum;
                end
                $display("word seq=%02h idx=%0d data=%02h sop=%0b eop=%0b pad=%0b", exp_seq, w,
                         bus.out_data, bus.out_sop, bus.out_eop, bus.out_padded);
                chk($sformatf("word%0d_data", w), bus.out_data, exp_w);
                chk($sformatf("word%0d_flags", w), {bus.out_sop, bus.out_eop, bus.out_padded},
                    {w == 0, w == 18, (w == 18) && exp_pad});
                if (bus.out_eop) begin
                    done = 1;
                    last_eop_cyc = cyc;
                    chk("frame_len", w, 18);
                end
                w++;
            end
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL frame_timeout: got no eop after %0d cycles, expected eop", iter);
        end
        @(negedge rdclk);
        exp_frames++;
        chk("frames_sent", bus.frames_sent, exp_frames);
        chk("pop_count", pops - pops0, (n_avail < 16) ? n_avail : 16);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1, s1, p0, k;

        vecs[0] = '{16, 8'h01, 8'h01, 1'b0, 2, 8'h00, 8'h88, 1'b0};
        vecs[1] = '{16, 8'h10, 8'h10, 1'b0, 0, 8'h01, 8'h80, 1'b0};
        vecs[2] = '{16, 8'hF0, 8'h01, 1'b1, 0, 8'h02, 8'h78, 1'b0};
        vecs[3] = '{ 5, 8'h03, 8'h07, 1'b0, 0, 8'h03, 8'h55, 1'b1};
        vecs[4] = '{ 1, 8'hFF, 8'h00, 1'b0, 0, 8'h04, 8'hFF, 1'b1};
        vecs[5] = '{16, 8'h80, 8'h80, 1'b1, 0, 8'h05, 8'h00, 1'b0};

        // Reset state, with data present and enable high
        PresetFull    = 1'b1;
        bus.enable    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge rdclk);
        load_words(8'h01, 8'h01, 16);
        bus.enable = 1'b1;
        repeat (2) @(negedge rdclk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_flags", {bus.out_sop, bus.out_eop, bus.out_padded}, 0);
        chk("rst_frames", bus.frames_sent, 0);
        chk("rst_rdreq", bus.fifo_rdreq, 0);
        chk("rst_pops", pops, 0);
        PresetFull = 1'b0;

        // Table-driven frames: full, wrap-around data, ready toggling, starvation padding
        for (int i = 0; i < 6; i++) begin
            if (i != 0) load_words(vecs[i].first, vecs[i].step, vecs[i].n_avail);
            run_frame(vecs[i].n_avail, vecs[i].toggle, vecs[i].exp_lat, 1'b0,
                      vecs[i].exp_seq, vecs[i].exp_csum, vecs[i].exp_pad);
        end

        // Back-to-back frames: full throughput inside, one bubble between
        load_words(8'h01, 8'h01, 16);
        load_words(8'h02, 8'h02, 16);
        run_frame(16, 1'b0, 0, 1'b0, 8'h06, 8'h88, 1'b0);
        e1 = last_eop_cyc;
        s1 = last_sop_cyc;
        chk("b2b_throughput", e1 - s1, 18);
        run_frame(16, 1'b0, 0, 1'b0, 8'h07, 8'h10, 1'b0);
        chk("b2b_gap", last_sop_cyc - e1, 2);

        // Reset mid-payload drops the frame; next frame restarts at seq 00
        load_words(8'h01, 8'h01, 16);
        p0 = pops;
        for (int t = 0; t < 100 && (pops - p0) < 3; t++) @(negedge rdclk);
        chk("t5_in_payload", (pops - p0) >= 3, 1);
        PresetFull = 1'b1;
        #1;
        chk("t5_valid", bus.out_valid, 0);
        chk("t5_data", bus.out_data, 0);
        chk("t5_flags", {bus.out_sop, bus.out_eop, bus.out_padded}, 0);
        chk("t5_rdreq", bus.fifo_rdreq, 0);
        chk("t5_frames", bus.frames_sent, 0);
        k = pops - p0;
        @(negedge rdclk);
        chk("t5_no_pop", pops - p0, k);
        PresetFull = 1'b0;
        for (int i = 0; i < k; i++) void'(exp_q.pop_front());
        load_words(8'h01, 8'h01, k);
        exp_frames = 0;
        run_frame(16, 1'b0, 2, 1'b0, 8'h00, 8'h88, 1'b0);

        // enable low holds the packer idle; dropping enable mid-frame does not abort it
        bus.enable = 1'b0;
        load_words(8'h09, 8'h01, 16);
        p0 = pops;
        for (int t = 0; t < 20; t++) begin
            @(negedge rdclk);
            chk("t6_idle_rdreq", bus.fifo_rdreq, 0);
            chk("t6_idle_valid", bus.out_valid, 0);
        end
        chk("t6_idle_pops", pops - p0, 0);
        bus.enable = 1'b1;
        run_frame(16, 1'b0, 2, 1'b1, 8'h01, 8'h08, 1'b0);

        // Sequence number wraps FF -> 00
        bus.enable = 1'b1;
        for (int f = 0; f < 256; f++) begin
            load_words(8'h01, 8'h00, 16);
            run_frame(16, 1'b0, 0, 1'b0, 8'(f + 2), 8'h10, 1'b0);
        end
        chk("wrap_frames_total", bus.frames_sent, 16'd258);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
